// File: rtl/transmit_arbiter.sv
// -----------------------------------------------------------------------------
// transmit_arbiter
//
// Packet-granular round-robin arbiter that lets NUM byte-stream producers
// share a single UART transmitter. A requester keeps the grant from its first
// accepted byte until the byte flagged last, or until it has left req_stb low
// for TIMEOUT consecutive cycles mid-packet. The search pointer moves past the
// released grantee, so every pending requester is served in turn.
//
// Optional feature (compile-time macro TRANSMIT_ARBITER_TAG_EN):
//   when defined, every grant first emits one tag byte (8'h80 | gnt) to the
//   transmitter before the requester's bytes are passed through.
//
// Parameters
//   NUM      number of requesters (2..16)
//   TIMEOUT  idle cycles tolerated mid-packet before the grant is revoked (>=2)
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-low reset
//   req_stb  per-requester byte valid, held until accepted
//   req_dat  per-requester byte, requester i on bits [8i+7:8i]
//   req_lst  per-requester "this byte ends the packet"
//   req_rdy  per-requester byte accepted this cycle
//   stb      byte valid towards the transmitter
//   dat      byte towards the transmitter
//   rdy      transmitter accepts the byte this cycle
//   gnt      index of the current (or most recent) grantee
//   busy     a grant is currently held
// -----------------------------------------------------------------------------
module transmit_arbiter #(
   parameter int NUM     = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM-1:0]          req_stb,
   input  logic [8*NUM-1:0]        req_dat,
   input  logic [NUM-1:0]          req_lst,
   output logic [NUM-1:0]          req_rdy,
   output logic                    stb,
   output logic [7:0]              dat,
   input  logic                    rdy,
   output logic [$clog2(NUM)-1:0]  gnt,
   output logic                    busy
);

   localparam int GW = $clog2(NUM);
   localparam int CW = $clog2(TIMEOUT);

`ifdef TRANSMIT_ARBITER_TAG_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TAG  = 2'd1,
      S_DATA = 2'd2
   } state_t;
`else
   typedef enum logic {
      S_IDLE = 1'b0,
      S_DATA = 1'b1
   } state_t;
`endif

   state_t          state_reg;
   logic [GW-1:0]   ptr_reg;
   logic [CW-1:0]   idle_cnt_reg;

   // Per-requester byte lanes
   logic [7:0]      lane [NUM];

   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
         assign lane[gi] = req_dat[8*gi +: 8];
      end
   endgenerate

   // Signals of the current grantee
   logic            sel_stb;
   logic            sel_lst;
   logic [7:0]      sel_dat;
   logic [GW-1:0]   next_ptr;

   assign sel_stb  = req_stb[gnt];
   assign sel_lst  = req_lst[gnt];
   assign sel_dat  = lane[gnt];
   assign next_ptr = (gnt == GW'(NUM - 1)) ? '0 : gnt + 1'b1;

   // Round-robin search starting at ptr_reg. Scanning offsets from the far end
   // down to zero lets the nearest pending requester overwrite earlier hits.
   logic            found;
   logic [GW-1:0]   win;
   logic [GW:0]     cand;

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = NUM - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_reg} + (GW+1)'(k);
         if (cand >= (GW+1)'(NUM)) begin
            cand = cand - (GW+1)'(NUM);
         end
         if (req_stb[cand[GW-1:0]]) begin
            found = 1'b1;
            win   = cand[GW-1:0];
         end
      end
   end

   // Grant state machine; gnt and busy are registered here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         gnt          <= '0;
         busy         <= 1'b0;
         ptr_reg      <= '0;
         idle_cnt_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (found) begin
                  gnt          <= win;
                  busy         <= 1'b1;
                  idle_cnt_reg <= '0;
`ifdef TRANSMIT_ARBITER_TAG_EN
                  state_reg    <= S_TAG;
`else
                  state_reg    <= S_DATA;
`endif
               end
            end
`ifdef TRANSMIT_ARBITER_TAG_EN
            S_TAG: begin
               // The idle counter is frozen while the tag byte waits
               if (rdy) begin
                  state_reg <= S_DATA;
               end
            end
`endif
            S_DATA: begin
               if (sel_stb) begin
                  idle_cnt_reg <= '0;
                  if (rdy && sel_lst) begin
                     state_reg <= S_IDLE;
                     busy      <= 1'b0;
                     ptr_reg   <= next_ptr;
                  end
               end else if (idle_cnt_reg == CW'(TIMEOUT - 1)) begin
                  // This low cycle is the TIMEOUT-th in a row: revoke
                  state_reg    <= S_IDLE;
                  busy         <= 1'b0;
                  ptr_reg      <= next_ptr;
                  idle_cnt_reg <= '0;
               end else begin
                  idle_cnt_reg <= idle_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Byte path: combinational pass-through from the grantee while in DATA
   always_comb begin
      stb     = 1'b0;
      dat     = 8'h00;
      req_rdy = '0;
      case (state_reg)
`ifdef TRANSMIT_ARBITER_TAG_EN
         S_TAG: begin
            stb = 1'b1;
            dat = 8'h80 | 8'(gnt);
         end
`endif
         S_DATA: begin
            stb          = sel_stb;
            dat          = sel_dat;
            req_rdy[gnt] = rdy;
         end
         default: begin
            stb     = 1'b0;
            dat     = 8'h00;
            req_rdy = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_transmit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_transmit_arbiter
//
// Requester drivers present queued packets (with per-byte idle gaps) and a
// randomly stalling transmitter. Every byte handed to a driver is also pushed
// onto a per-requester expected queue. An independent monitor follows the
// arbitration rules cycle by cycle (round-robin pick from the pointer, release
// on last byte or after TIMEOUT low cycles, optional tag byte) and pops the
// expected queue of the grantee on every accepted byte.
// -----------------------------------------------------------------------------
module tb_transmit_arbiter;

   localparam int NUM     = 4;
   localparam int TIMEOUT = 8;
   localparam int GW      = $clog2(NUM);

`ifdef TRANSMIT_ARBITER_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NUM-1:0]      req_stb;
   logic [8*NUM-1:0]    req_dat;
   logic [NUM-1:0]      req_lst;
   logic [NUM-1:0]      req_rdy;
   logic                stb;
   logic [7:0]          dat;
   logic                rdy;
   logic [GW-1:0]       gnt;
   logic                busy;

   always #5 clk = ~clk;

   transmit_arbiter #(
      .NUM     (NUM),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_stb (req_stb),
      .req_dat (req_dat),
      .req_lst (req_lst),
      .req_rdy (req_rdy),
      .stb     (stb),
      .dat     (dat),
      .rdy     (rdy),
      .gnt     (gnt),
      .busy    (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bit_of(input logic [NUM-1:0] v, input int idx);
      logic [NUM-1:0] t;
      t = v >> idx;
      return t[0];
   endfunction

   // ---------------------------------------------------------------- stimulus
   typedef struct packed {
      logic [31:0] gap;
      logic        lst;
      logic [7:0]  d;
   } ent_t;

   ent_t        drv_q [NUM][$];
   logic [8:0]  exp_q [NUM][$];
   int          gap_left   [NUM];
   bit          gap_loaded [NUM];
   logic [NUM-1:0] acc;
   int          rdy_pct = 100;

   function automatic void enq(input int i, input logic [7:0] d, input logic l, input int g);
      ent_t e;
      e.gap = 32'(g);
      e.lst = l;
      e.d   = d;
      drv_q[i].push_back(e);
      exp_q[i].push_back({l, d});
   endfunction

   // Requester and transmitter driver: inputs change 1 time unit after posedge
   initial begin
      ent_t dummy;
      req_stb = '0;
      req_dat = '0;
      req_lst = '0;
      rdy     = 1'b1;
      acc     = '0;
      for (int i = 0; i < NUM; i++) begin
         gap_left[i]   = 0;
         gap_loaded[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         acc = req_stb & req_rdy;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM; i++) begin
            if (acc[i] && drv_q[i].size() > 0) begin
               dummy = drv_q[i].pop_front();
               gap_loaded[i] = 1'b0;
            end
            if (drv_q[i].size() == 0) begin
               req_stb[i] = 1'b0;
            end else begin
               if (!gap_loaded[i]) begin
                  gap_left[i]   = int'(drv_q[i][0].gap);
                  gap_loaded[i] = 1'b1;
               end
               if (gap_left[i] > 0) begin
                  gap_left[i]--;
                  req_stb[i] = 1'b0;
               end else begin
                  req_stb[i]         = 1'b1;
                  req_dat[8*i +: 8]  = drv_q[i][0].d;
                  req_lst[i]         = drv_q[i][0].lst;
               end
            end
         end
         rdy = ($urandom_range(99) < rdy_pct);
      end
   end

   // ---------------------------------------------------------------- monitor
   initial begin
      bit         e_busy;
      bit         e_tag;
      int         e_gnt;
      int         e_ptr;
      int         e_cnt;
      int         w;
      int         idx;
      logic [8:0] ex;
      e_busy = 1'b0;
      e_tag  = 1'b0;
      e_gnt  = 0;
      e_ptr  = 0;
      e_cnt  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("rst_stb",  32'(stb),     32'd0);
            check("rst_dat",  32'(dat),     32'd0);
            check("rst_rdy",  32'(req_rdy), 32'd0);
            check("rst_busy", 32'(busy),    32'd0);
            check("rst_gnt",  32'(gnt),     32'd0);
            e_busy = 1'b0;
            e_tag  = 1'b0;
            e_gnt  = 0;
            e_ptr  = 0;
            e_cnt  = 0;
         end else begin
            check("busy", 32'(busy), 32'(e_busy));
            check("gnt",  32'(gnt),  32'(e_gnt));
            if (!e_busy) begin
               check("idle_stb", 32'(stb),     32'd0);
               check("idle_rdy", 32'(req_rdy), 32'd0);
               if (req_stb != '0) begin
                  w = -1;
                  for (int k = 0; k < NUM; k++) begin
                     idx = (e_ptr + k) % NUM;
                     if (w < 0 && bit_of(req_stb, idx)) w = idx;
                  end
                  e_busy = 1'b1;
                  e_gnt  = w;
                  e_tag  = TAG_EN;
                  e_cnt  = 0;
                  $display("grant: req %0d (ptr %0d, pending 0x%0h)", w, e_ptr, req_stb);
               end
            end else if (e_tag) begin
               check("tag_stb", 32'(stb),     32'd1);
               check("tag_dat", 32'(dat),     32'(8'h80 | 8'(e_gnt)));
               check("tag_rdy", 32'(req_rdy), 32'd0);
               if (rdy) begin
                  e_tag = 1'b0;
                  $display("xfer: tag 0x%02h", 8'h80 | 8'(e_gnt));
               end
            end else begin
               check("data_stb", 32'(stb), 32'(bit_of(req_stb, e_gnt)));
               check("data_rdy", 32'(req_rdy), rdy ? (32'd1 << e_gnt) : 32'd0);
               if (bit_of(req_stb, e_gnt)) begin
                  e_cnt = 0;
                  if (rdy) begin
                     if (exp_q[e_gnt].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%02h from req %0d, expected none", dat, e_gnt);
                     end else begin
                        ex = exp_q[e_gnt].pop_front();
                        check("data_byte", 32'(dat), 32'(ex[7:0]));
                        $display("xfer: req %0d byte 0x%02h lst %0d", e_gnt, dat, ex[8]);
                        if (ex[8]) begin
                           e_busy = 1'b0;
                           e_ptr  = (e_gnt + 1) % NUM;
                        end
                     end
                  end
               end else begin
                  e_cnt++;
                  if (e_cnt == TIMEOUT) begin
                     $display("timeout: req %0d released", e_gnt);
                     e_busy = 1'b0;
                     e_ptr  = (e_gnt + 1) % NUM;
                     e_cnt  = 0;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- sequence
   function automatic int pending_total();
      int s;
      s = 0;
      for (int i = 0; i < NUM; i++) s += exp_q[i].size();
      return s;
   endfunction

   task automatic drain(input string name, input int budget);
      int cyc;
      cyc = 0;
      while (cyc < budget) begin
         @(negedge clk);
         #2;
         if (pending_total() == 0 && busy == 1'b0) break;
         cyc++;
      end
      if (cyc >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: %0d bytes still pending, expected 0 within %0d cycles", name, pending_total(), budget);
      end
   endtask

   initial begin
      int len;
      int r;
      int g;
      rst = 1'b0;
      @(negedge clk);
      #2;
      // Reset held while every requester is pending
      for (int i = 0; i < NUM; i++) enq(i, 8'(8'hA0 + i), 1'b1, 0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drain("reset", 200);

      // Single two-byte packet from requester 2
      enq(2, 8'h55, 1'b0, 0);
      enq(2, 8'haa, 1'b1, 0);
      drain("single", 200);

      // All four requesters with back-to-back one-byte packets
      for (int rr = 0; rr < 2; rr++)
         for (int i = 0; i < NUM; i++) enq(i, 8'(8'h10 + i), 1'b1, 0);
      drain("all_four", 400);

      // Requester 1 pauses one cycle short of the timeout: grant held
      enq(1, 8'h21, 1'b0, 0);
      enq(1, 8'h22, 1'b0, TIMEOUT - 1);
      enq(1, 8'h23, 1'b1, 0);
      drain("hold", 400);

      // Requester 1 pauses past the timeout while requester 3 waits
      enq(1, 8'h31, 1'b0, 0);
      enq(1, 8'h32, 1'b1, TIMEOUT + 4);
      repeat (3) @(negedge clk);
      #2;
      enq(3, 8'h3f, 1'b1, 0);
      drain("timeout", 400);

      // Requesters 0 and 3 always pending with three-byte packets
      for (int p = 0; p < 3; p++) begin
         for (int b = 0; b < 3; b++) begin
            enq(0, 8'(8'h40 + 4*p + b), b == 2, 0);
            enq(3, 8'(8'hc0 + 4*p + b), b == 2, 0);
         end
      end
      drain("fair", 600);

      // Random traffic with a stalling transmitter
      rdy_pct = 70;
      for (int batch = 0; batch < 5; batch++) begin
         for (int p = 0; p < 30; p++) begin
            r   = $urandom_range(NUM - 1);
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) begin
               g = ($urandom_range(9) == 0) ? TIMEOUT + $urandom_range(3) : $urandom_range(3);
               enq(r, 8'($urandom_range(255)), b == len - 1, g);
            end
         end
         drain("random", 20000);
      end

      check("exp_empty", 32'(pending_total()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/transmit_arbiter.md
# transmit_arbiter

Round-robin arbiter that shares one `transmit` UART transmitter among `NUM` byte-stream requesters. Grants are packet-granular: a requester keeps the transmitter from its first accepted byte until the byte flagged last, or until an idle timeout. Sits between on-chip producers (debug, status, reply paths) and the single `transmit` instance driving `txd`.

## Interface
- `NUM`, 4: number of requesters, 2..16.
- `TIMEOUT`, 1024: cycles a granted requester may leave `req_stb` low mid-packet before its grant is revoked; ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_stb`  in  NUM  per-requester byte valid. Held until accepted.
- `req_dat`  in  8*NUM  per-requester byte; requester i uses bits [8i+7:8i].
- `req_lst`  in  NUM  byte presented is the last byte of the packet.
- `req_rdy`  out  NUM  byte accepted this cycle; transfer = `req_stb[i] & req_rdy[i]` at posedge.
- `stb`  out  1  byte valid to `transmit`.
- `dat`  out  8  byte to `transmit`.
- `rdy`  in  1  `transmit` accepts; transfer = `stb & rdy` at posedge.
- `gnt`  out  $clog2(NUM)  index of current/last grantee.
- `busy`  out  1  a grant is held.

## Operation
- States: IDLE, TAG (only with macro), DATA.
- IDLE: search `req_stb` starting at pointer `ptr`, wrapping modulo NUM; first set bit wins. Winner → `gnt`, `busy`=1, next state TAG or DATA. No request: remain.
- DATA: `stb = req_stb[gnt]`, `dat = req_dat[gnt]`, `req_rdy[gnt] = rdy`; all other `req_rdy` bits 0. Combinational pass-through, no added latency per byte.
- Transfer with `req_lst[gnt]`=1 → IDLE, `busy`=0, `ptr = (gnt+1) mod NUM`.
- Idle counter: in DATA, counts cycles with `req_stb[gnt]`=0; cleared by any cycle with `req_stb[gnt]`=1. Reaching TIMEOUT → IDLE, `ptr` advanced as above, `busy`=0.
- Non-granted requesters see `req_rdy`=0 and must hold their bytes.
- `gnt` retains last value in IDLE.
- Requester changing `req_dat` while `req_stb` high and unaccepted: protocol violation, undefined.

## Timing
- Reset values: `stb`=0, `dat`=0, `req_rdy`=0, `gnt`=0, `busy`=0, `ptr`=0, idle counter 0, state IDLE.
- Reset assertion mid-packet: immediate return to reset values; byte in flight inside `transmit` is not tracked.
- Arbitration latency: request in IDLE at cycle n → `busy`=1 and (no macro) `stb` valid at cycle n+1.
- Back-to-back packets: last-byte transfer at cycle n → IDLE at n+1 → next grant at n+2 (one idle cycle minimum between packets).
- Single-byte packet (`req_lst`=1 on first byte) releases after that one transfer.
- Timeout: grant released on the cycle the counter reaches TIMEOUT; i.e. TIMEOUT consecutive low cycles.
- All outputs except `stb`/`dat`/`req_rdy` in DATA are registered.

## Configuration
- `TRANSMIT_ARBITER_TAG_EN` defined: after each grant, state TAG drives `stb`=1, `dat = 8'h80 | gnt`, all `req_rdy`=0; on `rdy` transfer → DATA. Idle counter does not run in TAG. Arbitration-to-first-data latency becomes 1 cycle + tag acceptance.
- Undefined: TAG state absent; IDLE goes directly to DATA; no extra bytes on `txd`.

## Test plan
- Reset: hold `rst`=0 with all `req_stb`=1 → `stb`=0, `req_rdy`=0, `busy`=0, `gnt`=0; release → grant to 0 next cycle.
- Single requester 2, packet 8'h55, 8'haa (lst on second) → `txd` carries 0x55, 0xaa in order; `busy` drops one cycle after 0xaa accepted; `gnt`=2.
- All four requesting 1-byte packets 0x10..0x13 continuously → grant order 0,1,2,3,0; each packet preceded by exactly one IDLE cycle.
- Requester 1 mid-packet drops `req_stb` for TIMEOUT-1 cycles then resumes → grant held; drop for TIMEOUT cycles while requester 3 waits → grant moves to 3, requester 1 later re-arbitrates.
- Contention fairness: requesters 0 and 3 always pending, 3-byte packets → alternating 0,3,0,3; no interleaving of bytes within a packet.
- With `TRANSMIT_ARBITER_TAG_EN`: requester 3 sends 8'h41 (lst) → `txd` carries 0x83 then 0x41; `req_rdy[3]` never high during tag.
